stopwatch_adjust_unit: RTL and testbench
========================================

Name: stopwatch_adjust_unit

Overview:
Time-adjust and preset-select unit for the BCD MM:SS stopwatch.
- On an ADD/SUBTRACT request it steps the captured time by a BCD number of minutes and clamps the result to the legal window.
- On RESET it selects the start preset that matches the count direction.
- It also produces the minute-units carry/borrow enable for the counter chain.
- It sits between the previous-time register and the counter loader.

Parameters:
STEP_MIN, 1, minutes added/subtracted per request; legal range 1..9, applied as a BCD step on the minute-units digit.
MIN_PRESET, 16'h1020, lower bound and up-count start value (10:20), BCD.
MAX_PRESET, 16'h4930, upper bound and down-count start value (49:30), BCD.

Ports:
clk_in  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
REVERSE  input  1  count direction: 0 = up, 1 = down.
RESET  input  1  preset-load request (functional, not the block reset).
ADD  input  1  add STEP_MIN minutes.
SUBTRACT  input  1  subtract STEP_MIN minutes.
PREV_Q  input  16  captured time, BCD: [15:12] min tens, [11:8] min units, [7:4] sec tens, [3:0] sec units.
LOAD  output  1  registered; loader strobe, valid for one cycle.
LOAD_VALUE  output  16  registered BCD value to load.
SIGNAL  output  1  registered; adjustment hit a bound and was clamped.
INDEX_RESET  output  1  registered preset index: 0 = MIN_PRESET, 1 = MAX_PRESET.
CARRY_EN  output  1  combinational minute-units boundary flag.

Behaviour:
- Reset: when rst_n=0 at a clock edge, LOAD, LOAD_VALUE, SIGNAL and INDEX_RESET all go to 0. rst_n overrides every request.
- Latency: the request is sampled at edge N; outputs are valid after edge N and remain for exactly one cycle. With no request, LOAD=0 and SIGNAL=0, and LOAD_VALUE/INDEX_RESET hold their last values.
- Priority: RESET beats ADD/SUBTRACT. ADD and SUBTRACT together with no RESET is a no-op (LOAD=0).
- RESET: LOAD=1, INDEX_RESET=REVERSE, LOAD_VALUE = REVERSE ? MAX_PRESET : MIN_PRESET, SIGNAL=0.
- ADD:
  - Compute PREV_Q + STEP_MIN minutes in BCD; minute units carry into minute tens.
  - Seconds digits pass through unchanged.
  - If the result exceeds MAX_PRESET (numeric MM:SS compare), or minute tens would exceed 9: LOAD_VALUE=MAX_PRESET, SIGNAL=1, INDEX_RESET=1.
  - Otherwise LOAD_VALUE=result, SIGNAL=0.
  - LOAD=1.
- SUBTRACT:
  - Compute the BCD difference with borrow from minute tens.
  - If the result is below MIN_PRESET, or a borrow occurs out of minute tens: LOAD_VALUE=MIN_PRESET, SIGNAL=1, INDEX_RESET=0.
  - Otherwise LOAD_VALUE=result, SIGNAL=0.
  - LOAD=1.
- Out-of-window PREV_Q: clamped by the same rules. Non-BCD digits (>9) are not detected; the result is unspecified.
- CARRY_EN (combinational from PREV_Q[11:8]): 1 when REVERSE=0 and digit==9, or when REVERSE=1 and digit==0; otherwise 0.
- INDEX_RESET truth summary: RESET ? REVERSE : (SIGNAL ? ADD : previous).

Optional Feature:
Macro STOPWATCH_ADJ_WRAP_EN.
- Defined: a bound hit wraps instead of clamping. ADD overflow loads MIN_PRESET with INDEX_RESET=0; SUBTRACT underflow loads MAX_PRESET with INDEX_RESET=1. SIGNAL is still 1.
- Undefined: saturating clamp as described in Behaviour.

Decomposition:
- Package stopwatch_pkg:
  - typedef bcd_time_t (struct of four 4-bit digits);
  - constants for the MIN_PRESET/MAX_PRESET defaults;
  - function bcd_time_lt (numeric compare of two BCD times).
- One sub-module, bcd_minute_stepper: combinational BCD add/subtract of the minute digits.
  - Outputs the result, carry-out and borrow-out.
  - Instantiated once and driven by ADD/SUBTRACT.
- Clamp logic, preset-select logic, CARRY_EN and output registers live in the top module.

Test Plan:
- rst_n=0 with ADD=1 on the same edge -> LOAD=0, LOAD_VALUE=0, SIGNAL=0, INDEX_RESET=0.
- PREV_Q=16'h2345, ADD -> LOAD=1, LOAD_VALUE=16'h2445, SIGNAL=0. PREV_Q=16'h1930, ADD -> 16'h2030 (BCD carry).
- PREV_Q=16'h4910, ADD -> LOAD_VALUE=16'h4930, SIGNAL=1, INDEX_RESET=1. With STOPWATCH_ADJ_WRAP_EN defined -> 16'h1020, INDEX_RESET=0.
- PREV_Q=16'h2015, SUBTRACT -> 16'h1915. PREV_Q=16'h1050, SUBTRACT -> 16'h1020, SIGNAL=1, INDEX_RESET=0.
- RESET with REVERSE=0 -> LOAD_VALUE=16'h1020, INDEX_RESET=0. RESET with REVERSE=1 plus ADD -> 16'h4930, INDEX_RESET=1 (RESET wins). ADD+SUBTRACT together -> LOAD=0.
- CARRY_EN: REVERSE=0 with PREV_Q[11:8]=9 -> 1; REVERSE=0 with 8 -> 0; REVERSE=1 with 0 -> 1; REVERSE=1 with 9 -> 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the MM:SS stopwatch adjust path.
//   bcd_time_t     : four BCD digits, minute tens down to second units
//   *_PRESET_DEF   : default window bounds / start presets
//   bcd_time_lt    : numeric compare of two BCD times
package stopwatch_pkg;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_units;
        logic [3:0] sec_tens;
        logic [3:0] sec_units;
    } bcd_time_t;

    localparam logic [15:0] MIN_PRESET_DEF = 16'h1020;
    localparam logic [15:0] MAX_PRESET_DEF = 16'h4930;

    // With valid BCD digits, most-significant digit first, a plain unsigned
    // compare of the packed nibbles orders the times numerically.
    function automatic logic bcd_time_lt(input bcd_time_t a, input bcd_time_t b);
        logic [15:0] av;
        logic [15:0] bv;
        av = a;
        bv = b;
        return av < bv;
    endfunction

endpackage

// File: rtl/bcd_minute_stepper.sv
// Combinational BCD add/subtract of a single-digit step on the minute digits.
//   min_tens, min_units : current minute digits (BCD)
//   step                : step applied to minute units (BCD 1..9)
//   sub                 : 0 = add, 1 = subtract
//   res_tens, res_units : resulting minute digits (wrapped mod 100)
//   carry_out           : add overflowed out of minute tens
//   borrow_out          : subtract borrowed out of minute tens
module bcd_minute_stepper (
    input  logic [3:0] min_tens,
    input  logic [3:0] min_units,
    input  logic [3:0] step,
    input  logic       sub,
    output logic [3:0] res_tens,
    output logic [3:0] res_units,
    output logic       carry_out,
    output logic       borrow_out
);

    logic [4:0] u, t, s, us, ts;
    logic       mid;  // carry/borrow from units into tens

    always_comb begin
        u          = {1'b0, min_units};
        t          = {1'b0, min_tens};
        s          = {1'b0, step};
        us         = '0;
        ts         = '0;
        mid        = 1'b0;
        carry_out  = 1'b0;
        borrow_out = 1'b0;
        if (!sub) begin
            us = u + s;
            if (us > 5'd9) begin
                us  = us - 5'd10;
                mid = 1'b1;
            end
            ts = t + {4'b0, mid};
            if (ts > 5'd9) begin
                ts        = ts - 5'd10;
                carry_out = 1'b1;
            end
        end else begin
            if (u < s) begin
                us  = u + 5'd10 - s;
                mid = 1'b1;
            end else begin
                us = u - s;
            end
            if (t < {4'b0, mid}) begin
                ts         = t + 5'd10 - {4'b0, mid};
                borrow_out = 1'b1;
            end else begin
                ts = t - {4'b0, mid};
            end
        end
        res_units = us[3:0];
        res_tens  = ts[3:0];
    end

endmodule

// File: rtl/stopwatch_adjust_unit.sv
// Time-adjust and preset-select unit for the BCD MM:SS stopwatch.
// Steps the captured time by STEP_MIN minutes on ADD/SUBTRACT, clamps to
// [MIN_PRESET, MAX_PRESET], picks the start preset on RESET, and flags the
// minute-units carry/borrow boundary for the counter chain.
// Build option: STOPWATCH_ADJ_WRAP_EN -- a bound hit wraps to the opposite
// preset instead of saturating.
// Ports:
//   clk_in, rst_n  : clock, synchronous active-low reset
//   REVERSE        : count direction (0 up, 1 down)
//   RESET          : preset-load request
//   ADD, SUBTRACT  : adjust requests
//   PREV_Q         : captured BCD time
//   LOAD           : one-cycle loader strobe (registered)
//   LOAD_VALUE     : BCD value to load (registered)
//   SIGNAL         : adjustment hit a bound (registered)
//   INDEX_RESET    : preset index, 0 = MIN, 1 = MAX (registered)
//   CARRY_EN       : minute-units boundary flag (combinational)
module stopwatch_adjust_unit
    import stopwatch_pkg::*;
#(
    parameter int unsigned  STEP_MIN   = 1,
    parameter logic [15:0]  MIN_PRESET = MIN_PRESET_DEF,
    parameter logic [15:0]  MAX_PRESET = MAX_PRESET_DEF
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        REVERSE,
    input  logic        RESET,
    input  logic        ADD,
    input  logic        SUBTRACT,
    input  logic [15:0] PREV_Q,
    output logic        LOAD,
    output logic [15:0] LOAD_VALUE,
    output logic        SIGNAL,
    output logic        INDEX_RESET,
    output logic        CARRY_EN
);

    localparam logic [3:0] STEP_BCD = 4'(STEP_MIN);

    bcd_time_t  prev;
    bcd_time_t  stepped;
    logic [3:0] res_tens, res_units;
    logic       carry_out, borrow_out;
    logic       over, under;

    logic        nxt_load, nxt_signal, nxt_index;
    logic [15:0] nxt_value;

    assign prev = PREV_Q;

    bcd_minute_stepper u_stepper (
        .min_tens   (prev.min_tens),
        .min_units  (prev.min_units),
        .step       (STEP_BCD),
        .sub        (SUBTRACT),
        .res_tens   (res_tens),
        .res_units  (res_units),
        .carry_out  (carry_out),
        .borrow_out (borrow_out)
    );

    assign stepped = '{min_tens: res_tens, min_units: res_units,
                       sec_tens: prev.sec_tens, sec_units: prev.sec_units};

    // Tens overflow/underflow wraps the digits mod 100, so the carry/borrow
    // must be folded in; the window compare alone would miss it.
    assign over  = carry_out  || bcd_time_lt(MAX_PRESET, stepped);
    assign under = borrow_out || bcd_time_lt(stepped, MIN_PRESET);

    always_comb begin
        nxt_load   = 1'b0;
        nxt_signal = 1'b0;
        nxt_value  = LOAD_VALUE;
        nxt_index  = INDEX_RESET;
        if (RESET) begin
            nxt_load  = 1'b1;
            nxt_index = REVERSE;
            nxt_value = REVERSE ? MAX_PRESET : MIN_PRESET;
        end else if (ADD && !SUBTRACT) begin
            nxt_load = 1'b1;
            if (over) begin
                nxt_signal = 1'b1;
`ifdef STOPWATCH_ADJ_WRAP_EN
                nxt_value  = MIN_PRESET;
                nxt_index  = 1'b0;
`else
                nxt_value  = MAX_PRESET;
                nxt_index  = 1'b1;
`endif
            end else begin
                nxt_value = stepped;
            end
        end else if (SUBTRACT && !ADD) begin
            nxt_load = 1'b1;
            if (under) begin
                nxt_signal = 1'b1;
`ifdef STOPWATCH_ADJ_WRAP_EN
                nxt_value  = MAX_PRESET;
                nxt_index  = 1'b1;
`else
                nxt_value  = MIN_PRESET;
                nxt_index  = 1'b0;
`endif
            end else begin
                nxt_value = stepped;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            LOAD        <= 1'b0;
            LOAD_VALUE  <= '0;
            SIGNAL      <= 1'b0;
            INDEX_RESET <= 1'b0;
        end else begin
            LOAD        <= nxt_load;
            LOAD_VALUE  <= nxt_value;
            SIGNAL      <= nxt_signal;
            INDEX_RESET <= nxt_index;
        end
    end

    assign CARRY_EN = REVERSE ? (prev.min_units == 4'd0) : (prev.min_units == 4'd9);

endmodule

// File: tb/tb_stopwatch_adjust_unit.sv
// Self-checking bench for stopwatch_adjust_unit: a decimal reference model
// predicts each registered response, which is queued at drive time and
// popped one edge later when the DUT output is sampled.
module tb_stopwatch_adjust_unit;

    localparam int unsigned STEP = 1;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        REVERSE = 1'b0, RESET = 1'b0, ADD = 1'b0, SUBTRACT = 1'b0;
    logic [15:0] PREV_Q = '0;
    logic        LOAD, SIGNAL, INDEX_RESET, CARRY_EN;
    logic [15:0] LOAD_VALUE;

    stopwatch_adjust_unit #(.STEP_MIN(STEP), .MIN_PRESET(16'h1020), .MAX_PRESET(16'h4930)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .REVERSE     (REVERSE),
        .RESET       (RESET),
        .ADD         (ADD),
        .SUBTRACT    (SUBTRACT),
        .PREV_Q      (PREV_Q),
        .LOAD        (LOAD),
        .LOAD_VALUE  (LOAD_VALUE),
        .SIGNAL      (SIGNAL),
        .INDEX_RESET (INDEX_RESET),
        .CARRY_EN    (CARRY_EN)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       tag;
        logic        load;
        logic [15:0] value;
        logic        sig;
        logic        idx;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_val = '0;
    logic        m_idx = 1'b0;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // Reference model in plain decimal minutes/seconds.
    task automatic apply(input string tag, input logic rn, input logic rv, input logic rs,
                         input logic ad, input logic sb_in, input logic [15:0] q);
        exp_t e;
        int   mm, ss, t;
        rst_n = rn; REVERSE = rv; RESET = rs; ADD = ad; SUBTRACT = sb_in; PREV_Q = q;
        e.tag = tag; e.load = 1'b0; e.sig = 1'b0;
        if (!rn) begin
            m_val = '0; m_idx = 1'b0;
        end else if (rs) begin
            e.load = 1'b1; m_idx = rv; m_val = rv ? 16'h4930 : 16'h1020;
        end else if (ad ^ sb_in) begin
            e.load = 1'b1;
            mm = 10 * int'(q[15:12]) + int'(q[11:8]);
            ss = 10 * int'(q[7:4]) + int'(q[3:0]);
            mm = ad ? mm + int'(STEP) : mm - int'(STEP);
            t  = mm * 100 + ss;
            if (ad && t > 4930) begin
                e.sig = 1'b1;
`ifdef STOPWATCH_ADJ_WRAP_EN
                m_val = 16'h1020; m_idx = 1'b0;
`else
                m_val = 16'h4930; m_idx = 1'b1;
`endif
            end else if (sb_in && (mm < 0 || t < 1020)) begin
                e.sig = 1'b1;
`ifdef STOPWATCH_ADJ_WRAP_EN
                m_val = 16'h4930; m_idx = 1'b1;
`else
                m_val = 16'h1020; m_idx = 1'b0;
`endif
            end else begin
                m_val = to_bcd(mm, ss);
            end
        end
        e.value = m_val; e.idx = m_idx;
        sb.push_back(e);
        @(posedge clk_in);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".load"},  16'(LOAD),        16'(e.load));
            chk({e.tag, ".value"}, LOAD_VALUE,       e.value);
            chk({e.tag, ".sig"},   16'(SIGNAL),      16'(e.sig));
            chk({e.tag, ".idx"},   16'(INDEX_RESET), 16'(e.idx));
        end
        ADD = 1'b0; SUBTRACT = 1'b0; RESET = 1'b0;
    endtask

    task automatic carry_chk(input string tag, input logic rv, input logic [3:0] mu, input logic exp);
        logic [15:0] q;
        q = 16'h2000 | {4'h0, mu, 8'h15};
        REVERSE = rv; PREV_Q = q;
        #1;
        chk(tag, 16'(CARRY_EN), 16'(exp));
    endtask

    initial begin
        logic [15:0] rq;
        int          op;
        @(posedge clk_in); #1;
        // reset dominates a simultaneous ADD
        apply("rst_add",     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2345);
        apply("add_2345",    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2345);
        apply("idle_hold",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        apply("add_carry",   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1930);
        apply("add_clamp",   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4910);
        apply("add_tens_ov", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h9905);
        apply("sub_borrow",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2015);
        apply("sub_clamp",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1050);
        apply("sub_tens_un", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0030);
        apply("sub_edge",    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1120);
        apply("add_edge",    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4830);
        apply("rst_up",      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3333);
        apply("rst_dn_add",  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h3333);
        apply("add_sub_nop", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2345);
        apply("idle2",       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2345);
        carry_chk("carry_up9",   1'b0, 4'd9, 1'b1);
        carry_chk("carry_up8",   1'b0, 4'd8, 1'b0);
        carry_chk("carry_dn0",   1'b1, 4'd0, 1'b1);
        carry_chk("carry_dn9",   1'b1, 4'd9, 1'b0);
        for (int i = 0; i < 60; i++) begin
            rq = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            op = $urandom_range(0, 5);
            apply("rand", 1'b1, 1'($urandom_range(0, 1)), 1'(op == 0),
                  1'(op == 1 || op == 2 || op == 5), 1'(op == 3 || op == 4 || op == 5), rq);
        end
        apply("rst_end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4930);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
